// File: rtl/sdram_avalon_arbiter.sv
// rtl/sdram_avalon_arbiter.sv - two-master round-robin Avalon-MM arbiter for the SDRAM controller
// A tag FIFO remembers which master issued each outstanding read so responses route back in order.
module sdram_avalon_arbiter #(
    parameter int ADDR_WIDTH  = 22,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [ADDR_WIDTH-1:0]         m0_address,
    input  logic                          m0_read,
    input  logic                          m0_write,
    input  logic [DATA_WIDTH-1:0]         m0_writedata,
    input  logic [1:0]                    m0_byteenable,
    output logic                          m0_waitrequest,
    output logic                          m0_readdatavalid,
    output logic [DATA_WIDTH-1:0]         m0_readdata,
    input  logic [ADDR_WIDTH-1:0]         m1_address,
    input  logic                          m1_read,
    input  logic                          m1_write,
    input  logic [DATA_WIDTH-1:0]         m1_writedata,
    input  logic [1:0]                    m1_byteenable,
    output logic                          m1_waitrequest,
    output logic                          m1_readdatavalid,
    output logic [DATA_WIDTH-1:0]         m1_readdata,
    output logic [ADDR_WIDTH-1:0]         s_address,
    output logic [DATA_WIDTH-1:0]         s_writedata,
    output logic [1:0]                    s_byteenable,
    output logic                          s_read,
    output logic                          s_write,
    input  logic                          s_waitrequest,
    input  logic                          s_readdatavalid,
    input  logic [DATA_WIDTH-1:0]         s_readdata,
    output logic [$clog2(MAX_PENDING):0]  pending,
    output logic                          err_orphan
);
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [MAX_PENDING-1:0] tag_q;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       pending_q, pending_d;
    logic                   err_orphan_q;

    logic g_read, g_write, fifo_empty, tag_full, push, pop, accept, head;
    logic m0_req, m1_req;

    assign m0_req     = m0_read | m0_write;
    assign m1_req     = m1_read | m1_write;
    assign fifo_empty = (pending_q == '0);
    assign head       = tag_q[rd_ptr_q];
    assign pop        = s_readdatavalid & ~fifo_empty & reset_reset_n;
    // A beat leaving this cycle frees a slot, so a read may enter a full FIFO alongside it.
    assign tag_full   = (pending_q == FULL_CNT) & ~pop;
    assign g_read     = grant_q ? m1_read  : m0_read;
    assign g_write    = grant_q ? m1_write : m0_write;

    assign s_address    = grant_q ? m1_address    : m0_address;
    assign s_writedata  = grant_q ? m1_writedata  : m0_writedata;
    assign s_byteenable = grant_q ? m1_byteenable : m0_byteenable;

    assign push      = accept & s_read;
    assign pending_d = pending_q + CNT_W'(push) - CNT_W'(pop);

    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop & head;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign pending          = pending_q;
    assign err_orphan       = err_orphan_q;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        s_read         = 1'b0;
        s_write        = 1'b0;
        accept         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m0_req | m1_req) begin
                    state_d = S_GRANT;
                    grant_d = (m0_req & m1_req) ? ~last_grant_q : m1_req;
                end
            end
            S_GRANT: begin
                s_read  = g_read & ~tag_full;
                s_write = g_write;
                accept  = (s_read | s_write) & ~s_waitrequest;
                if (grant_q) begin
                    m1_waitrequest = s_waitrequest | (g_read & tag_full);
                end else begin
                    m0_waitrequest = s_waitrequest | (g_read & tag_full);
                end
                if (accept) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end else if (~(g_read | g_write)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!reset_reset_n) begin
            m0_waitrequest = 1'b1;
            m1_waitrequest = 1'b1;
            s_read         = 1'b0;
            s_write        = 1'b0;
            accept         = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (s_readdatavalid & fifo_empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: only entries below the pending count are ever read.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            tag_q[wr_ptr_q] <= grant_q;
        end
    end
endmodule

// File: doc/sdram_avalon_arbiter.md
# sdram_avalon_arbiter

Two-master Avalon-MM arbiter that shares the single SDRAM controller slave port between the Clarvi instruction-fetch master (m0) and data master (m1) inside the SoC. It grants one master at a time with round-robin fairness and tracks outstanding pipelined reads in a tag FIFO, so that each `s_readdatavalid` beat is routed back to the master that issued it. It sits in the 50 MHz system clock domain, between the core's bus ports and the SDRAM controller.

## Interface
- `ADDR_WIDTH`, 22: halfword address width (12 row + 8 column + 2 bank).
- `DATA_WIDTH`, 16: SDRAM data width.
- `MAX_PENDING`, 8: tag FIFO depth; maximum number of outstanding reads. Power of two, ≥ 2.
- `clk_clk`  in  1  system clock; all logic on its rising edge.
- `reset_reset_n`  in  1  reset, synchronous, active-low.
- `mN_address`  in  ADDR_WIDTH  master N address (N = 0, 1).
- `mN_read`, `mN_write`  in  1  master N request strobes; never both high.
- `mN_writedata`  in  DATA_WIDTH  master N write data.
- `mN_byteenable`  in  2  master N byte enables.
- `mN_waitrequest`  out  1  stall to master N.
- `mN_readdatavalid`  out  1  read response valid for master N.
- `mN_readdata`  out  DATA_WIDTH  response data (shared bus, qualified per master).
- `s_address`, `s_writedata`, `s_byteenable`, `s_read`, `s_write`  out  —  widths as above; to the SDRAM controller.
- `s_waitrequest`, `s_readdatavalid`  in  1  from the SDRAM controller.
- `s_readdata`  in  DATA_WIDTH  from the SDRAM controller.
- `pending`  out  $clog2(MAX_PENDING)+1  outstanding read count.
- `err_orphan`  out  1  sticky flag: a response arrived with no tag.

## Operation
- **FSM states:**
  - IDLE: both `mN_waitrequest` = 1; `s_read` = `s_write` = 0.
    - If any master requests, register a grant to the winner and move to GRANT.
    - Winner when both request: the master other than `last_grant`.
    - Winner when one requests: that master.
  - GRANT(g):
    - `s_*` command signals are driven combinationally from master g.
    - `mg_waitrequest` = `s_waitrequest` | (`mg_read` & `tag_full`).
    - `s_read` = `mg_read` & ~`tag_full`.
    - The non-granted master's `waitrequest` = 1.
  - Accept occurs when (`s_read` | `s_write`) & ~`s_waitrequest`. On accept: `last_grant` ← g, return to IDLE.
  - If master g drops its request before accept (protocol violation), return to IDLE without updating `last_grant`.
- **Tag FIFO:**
  - An accepted read pushes g.
  - `s_readdatavalid` pops the head tag. Beat routed: `mN_readdatavalid` = `s_readdatavalid` & (head == N) & ~`empty`.
  - `mN_readdata` = `s_readdata` for both masters.
  - Push and pop in the same cycle: both happen, and `pending` is unchanged. This is legal when the FIFO is full.
  - `tag_full` = (`pending` == MAX_PENDING). While full, a new read is stalled; writes still proceed.
  - `s_readdatavalid` with the FIFO empty: the beat is dropped, no `mN_readdatavalid` is asserted, and `err_orphan` is set. The flag is cleared only by reset.
- **Writes** take no tag and produce no response.
- **Ordering:** responses return in issue order, so FIFO order equals response order.
- **Reset:**
  - Values while `reset_reset_n` is low at a clock edge: state = IDLE, `last_grant` = 1 (so m0 wins first contention), FIFO empty, `pending` = 0, `err_orphan` = 0.
  - Output values under reset: `mN_waitrequest` = 1, `mN_readdatavalid` = 0, `s_read` = `s_write` = 0.
  - Reset in the middle of a transaction discards all tags. Later responses from the controller count as orphans.

## Timing
- Arbitration costs 1 cycle: a request seen in IDLE at edge k puts the command on `s_*` during cycle k+1.
- Minimum occupancy is 2 cycles per accepted transaction (IDLE + GRANT), which gives peak throughput of 1 command per 2 cycles.
- Response path is combinational: `mN_readdatavalid` asserts in the same cycle as `s_readdatavalid`.
- `pending` is registered. It updates at the edge after a push or pop.
- With no `s_waitrequest` stalls and both masters requesting continuously, grants alternate m0, m1, m0, …

## Test plan
- **Single read:** reset, then m0 reads address 0x000010. Required: `s_read` high in cycle 2, accepted with `s_waitrequest` = 0, `pending` = 1. Slave returns 0xBEEF 3 cycles later: `m0_readdatavalid` = 1 with data 0xBEEF, `m1_readdatavalid` = 0, `pending` = 0.
- **Contention:** m0 and m1 both hold reads asserted from reset release. Required: accept order m0, m1, m0, m1. Responses 0x1111, 0x2222, 0x3333, 0x4444 are routed to m0, m1, m0, m1 respectively.
- **FIFO full:** MAX_PENDING = 8, slave withholds responses, m1 issues 9 reads. Required: 8 accepted; the 9th stalls (`m1_waitrequest` = 1, `s_read` = 0). A write from m0 is still accepted during the stall. One response beat lets the 9th read accept in that cycle; `pending` stays 8.
- **Slave stall:** `s_waitrequest` held high for 5 cycles during an m1 write. Required: `s_*` stable for all 5 cycles, `m0_waitrequest` = 1 throughout. Accept occurs on the 6th cycle.
- **Reset mid-operation:** 3 reads outstanding, then 1 cycle of `reset_reset_n` = 0, then 3 responses. Required: no `mN_readdatavalid`, `err_orphan` = 1, `pending` = 0.
- **Write then read, same master:** m0 writes 0xA5A5 with byteenable 2'b01, then reads. Required: the write produces no response and no tag; the read response is routed to m0.
